bus_arbiter: RTL and testbench

- Two-master, one-slave Wishbone-classic arbiter for the shared instruction/data memory bus.
- m0 is the IF-stage fetch port; m1 is the MEM-stage load/store port.
- Produces if_wait_o/mem_wait_o, which the pipeline stall/flush controller consumes as its instruction-memory and data-memory wait inputs.
- Supports IF-transaction cancellation on branch flush, and includes a bus watchdog.

---
 rtl/bus_arbiter_if.sv | 27 ++
 rtl/bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Wishbone-classic bus bundle. One instance per bus segment: each master
// port of the arbiter and the shared slave port. The master modport belongs
// to whoever starts cycles; the slave modport belongs to whoever answers them.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   wdat;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   rdat;
    logic                    ack;
    logic                    err;

    modport master (
        output cyc, stb, we, adr, wdat, sel,
        input  rdat, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, wdat, sel,
        output rdat, ack, err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master / one-slave Wishbone-classic arbiter for the shared memory bus.
// m0 is the IF fetch port (read only), m1 is the MEM load/store port.
// Alternating priority on contention, IF cancellation on branch flush, and a
// watchdog that aborts a transfer the slave never acknowledges.
module bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    bus_arbiter_if.master s,
    input  logic          flush_if_i,
    output logic          if_wait_o,
    output logic          mem_wait_o
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state;
    logic            last_owner;
    logic            drop;
    logic [TW-1:0]   timer;
    logic            err0_q;
    logic            err1_q;

    logic            req0;
    logic            req1;
    logic            grant0;
    logic            grant1;
    logic            own0;
    logic            own1;
    logic            timeout_hit;

    // m0 never writes, and the slave has no error line of its own; those
    // interface members are present only because the bundle is shared.
    logic unused_inputs;
    assign unused_inputs = ^{m0.we, m0.wdat, m0.sel, s.err};

    // Arbitration: a master whose error pulse is showing is not re-granted in
    // that same cycle, giving it the chance to drop its request first.
    always_comb begin
        own0        = (state == OWN0);
        own1        = (state == OWN1);
        req0        = m0.cyc & m0.stb & ~flush_if_i & ~err0_q;
        req1        = m1.cyc & m1.stb & ~err1_q;
        grant0      = req0 & (~req1 | last_owner);
        grant1      = req1 & (~req0 | ~last_owner);
        timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT)) && !s.ack;
    end

    // Master-side responses: only the owner sees slave data and ack.
    // A flushed fetch keeps its ack hidden from the IF stage.
    always_comb begin
        m0.rdat = own0 ? s.rdat : '0;
        m1.rdat = own1 ? s.rdat : '0;
        m0.ack  = own0 & s.ack & ~drop;
        m1.ack  = own1 & s.ack;
        m0.err  = err0_q;
        m1.err  = err1_q;
    end

    // Stall requests; forced low while reset is held so the pipeline never
    // sees a wait from a half-initialised arbiter.
    always_comb begin
        if_wait_o  = rst_n & m0.cyc & m0.stb & ~(own0 & s.ack & ~drop) & ~err0_q;
        mem_wait_o = rst_n & m1.cyc & m1.stb & ~(own1 & s.ack) & ~err1_q;
    end

    // Ownership FSM with registered slave-side bus and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b0;
            drop       <= 1'b0;
            timer      <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            s.cyc      <= 1'b0;
            s.stb      <= 1'b0;
            s.we       <= 1'b0;
            s.adr      <= '0;
            s.wdat     <= '0;
            s.sel      <= '0;
        end else begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0) begin
                        state      <= OWN0;
                        last_owner <= 1'b0;
                        drop       <= 1'b0;
                        timer      <= '0;
                        s.cyc      <= 1'b1;
                        s.stb      <= 1'b1;
                        s.we       <= 1'b0;
                        s.adr      <= m0.adr;
                        s.wdat     <= '0;
                        s.sel      <= '1;
                    end else if (grant1) begin
                        state      <= OWN1;
                        last_owner <= 1'b1;
                        drop       <= 1'b0;
                        timer      <= '0;
                        s.cyc      <= 1'b1;
                        s.stb      <= 1'b1;
                        s.we       <= m1.we;
                        s.adr      <= m1.adr;
                        s.wdat     <= m1.wdat;
                        s.sel      <= m1.sel;
                    end
                end
                OWN0, OWN1: begin
                    if (s.ack) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        s.cyc <= 1'b0;
                        s.stb <= 1'b0;
                    end else if (timeout_hit) begin
                        state  <= IDLE;
                        drop   <= 1'b0;
                        s.cyc  <= 1'b0;
                        s.stb  <= 1'b0;
                        err0_q <= own0 & ~drop;
                        err1_q <= own1;
                    end else begin
                        timer <= timer + TW'(1);
                        if (own0 && flush_if_i)
                            drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter, built with a short watchdog (TIMEOUT=4).
module tb_bus_arbiter;
    logic clk;
    logic rst_n;
    logic flush_if_i;
    logic if_wait_o;
    logic mem_wait_o;
    int   n_cmp;
    int   n_fail;

    bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0b ();
    bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1b ();
    bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sb ();

    bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0         (m0b),
        .m1         (m1b),
        .s          (sb),
        .flush_if_i (flush_if_i),
        .if_wait_o  (if_wait_o),
        .mem_wait_o (mem_wait_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0b.cyc = 0; m0b.stb = 0; m0b.we = 0; m0b.adr = '0; m0b.wdat = '0; m0b.sel = '0;
        m1b.cyc = 0; m1b.stb = 0; m1b.we = 0; m1b.adr = '0; m1b.wdat = '0; m1b.sel = '0;
        sb.rdat = '0; sb.ack = 0; sb.err = 0;
        flush_if_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        m0b.cyc = 1; m0b.stb = 1; m0b.adr = 32'h8000_0000;
        m1b.cyc = 1; m1b.stb = 1;
        step();
        n_cmp++; if (sb.cyc !== 1'b0) begin n_fail++; $display("FAIL rst_s_cyc: got %b expected 0", sb.cyc); end
        n_cmp++; if (sb.stb !== 1'b0) begin n_fail++; $display("FAIL rst_s_stb: got %b expected 0", sb.stb); end
        n_cmp++; if ({sb.we, sb.adr, sb.wdat, sb.sel} !== '0) begin n_fail++; $display("FAIL rst_s_bus: got %h expected 0", {sb.we, sb.adr, sb.wdat, sb.sel}); end
        n_cmp++; if ({m0b.ack, m0b.err, m1b.ack, m1b.err} !== 4'b0) begin n_fail++; $display("FAIL rst_ack_err: got %b expected 0000", {m0b.ack, m0b.err, m1b.ack, m1b.err}); end
        n_cmp++; if ({m0b.rdat, m1b.rdat} !== 64'h0) begin n_fail++; $display("FAIL rst_rdat: got %h expected 0", {m0b.rdat, m1b.rdat}); end
        n_cmp++; if ({if_wait_o, mem_wait_o} !== 2'b00) begin n_fail++; $display("FAIL rst_wait: got %b expected 00", {if_wait_o, mem_wait_o}); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_m1_write();
        m1b.cyc = 1; m1b.stb = 1; m1b.we = 1;
        m1b.adr = 32'h8000_0100; m1b.wdat = 32'hDEAD_BEEF; m1b.sel = 4'b1111;
        #1;
        n_cmp++; if (sb.cyc !== 1'b0) begin n_fail++; $display("FAIL wr_latency: got %b expected 0", sb.cyc); end
        n_cmp++; if (mem_wait_o !== 1'b1) begin n_fail++; $display("FAIL wr_wait_req: got %b expected 1", mem_wait_o); end
        step();
        n_cmp++; if ({sb.cyc, sb.stb, sb.we} !== 3'b111) begin n_fail++; $display("FAIL wr_strobes: got %b expected 111", {sb.cyc, sb.stb, sb.we}); end
        n_cmp++; if (sb.adr !== 32'h8000_0100) begin n_fail++; $display("FAIL wr_adr: got %h expected 80000100", sb.adr); end
        n_cmp++; if (sb.sel !== 4'b1111) begin n_fail++; $display("FAIL wr_sel: got %b expected 1111", sb.sel); end
        n_cmp++; if (m1b.ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_c1: got %b expected 0", m1b.ack); end
        m1b.wdat = 32'h0000_0000; m1b.adr = 32'h1234_5678;
        step();
        n_cmp++; if (sb.wdat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_dat_held: got %h expected deadbeef", sb.wdat); end
        n_cmp++; if (sb.adr !== 32'h8000_0100) begin n_fail++; $display("FAIL wr_adr_held: got %h expected 80000100", sb.adr); end
        n_cmp++; if ({m1b.ack, mem_wait_o} !== 2'b01) begin n_fail++; $display("FAIL wr_c2_ack_wait: got %b expected 01", {m1b.ack, mem_wait_o}); end
        step();
        sb.ack = 1; sb.rdat = 32'h1357_9BDF;
        #1;
        n_cmp++; if (m1b.ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b expected 1", m1b.ack); end
        n_cmp++; if (mem_wait_o !== 1'b0) begin n_fail++; $display("FAIL wr_wait_drop: got %b expected 0", mem_wait_o); end
        n_cmp++; if (m1b.rdat !== 32'h1357_9BDF) begin n_fail++; $display("FAIL wr_m1_rdat: got %h expected 13579bdf", m1b.rdat); end
        n_cmp++; if ({m0b.ack, m0b.rdat} !== 33'h0) begin n_fail++; $display("FAIL wr_m0_quiet: got %h expected 0", {m0b.ack, m0b.rdat}); end
        step();
        sb.ack = 0; sb.rdat = '0;
        m1b.cyc = 0; m1b.stb = 0; m1b.we = 0;
        #1;
        n_cmp++; if ({sb.cyc, sb.stb, m1b.ack} !== 3'b000) begin n_fail++; $display("FAIL wr_release: got %b expected 000", {sb.cyc, sb.stb, m1b.ack}); end
        step();
        n_cmp++; if (sb.cyc !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got %b expected 0", sb.cyc); end
    endtask

    task automatic test_alternation();
        logic        exp_owner [4];
        logic [31:0] exp_adr;
        exp_owner = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        m0b.cyc = 1; m0b.stb = 1; m0b.adr = 32'h8000_0000;
        m1b.cyc = 1; m1b.stb = 1; m1b.we = 1; m1b.adr = 32'h8000_0200;
        m1b.wdat = 32'h0BAD_F00D; m1b.sel = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 5 && sb.cyc !== 1'b1; k++) step();
            n_cmp++; if (sb.cyc !== 1'b1) begin n_fail++; $display("FAIL alt_grant%0d: got cyc %b expected 1", t, sb.cyc); end
            exp_adr = exp_owner[t] ? 32'h8000_0200 : 32'h8000_0000;
            n_cmp++; if (sb.adr !== exp_adr) begin n_fail++; $display("FAIL alt_adr%0d: got %h expected %h", t, sb.adr, exp_adr); end
            n_cmp++; if (sb.sel !== (exp_owner[t] ? 4'b0011 : 4'b1111)) begin n_fail++; $display("FAIL alt_sel%0d: got %b expected %b", t, sb.sel, exp_owner[t] ? 4'b0011 : 4'b1111); end
            sb.ack = 1; sb.rdat = 32'hC0DE_0000 + t;
            #1;
            n_cmp++; if ({m0b.ack, m1b.ack} !== (exp_owner[t] ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL alt_ack%0d: got %b expected %b", t, {m0b.ack, m1b.ack}, exp_owner[t] ? 2'b01 : 2'b10); end
            n_cmp++; if ({if_wait_o, mem_wait_o} !== (exp_owner[t] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_wait%0d: got %b expected %b", t, {if_wait_o, mem_wait_o}, exp_owner[t] ? 2'b10 : 2'b01); end
            step();
            sb.ack = 0; sb.rdat = '0;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_flush();
        m0b.cyc = 1; m0b.stb = 1; m0b.adr = 32'h8000_0000;
        #1;
        n_cmp++; if (if_wait_o !== 1'b1) begin n_fail++; $display("FAIL fl_wait_req: got %b expected 1", if_wait_o); end
        step();
        n_cmp++; if ({sb.cyc, sb.we, sb.sel, sb.wdat} !== {1'b1, 1'b0, 4'b1111, 32'h0}) begin n_fail++; $display("FAIL fl_read_shape: got %h expected read", {sb.cyc, sb.we, sb.sel, sb.wdat}); end
        n_cmp++; if (sb.adr !== 32'h8000_0000) begin n_fail++; $display("FAIL fl_adr: got %h expected 80000000", sb.adr); end
        step();
        flush_if_i = 1;
        step();
        flush_if_i = 0; m0b.cyc = 0; m0b.stb = 0;
        #1;
        n_cmp++; if (sb.cyc !== 1'b1) begin n_fail++; $display("FAIL fl_cyc_held: got %b expected 1", sb.cyc); end
        n_cmp++; if (if_wait_o !== 1'b0) begin n_fail++; $display("FAIL fl_wait_gone: got %b expected 0", if_wait_o); end
        step();
        sb.ack = 1; sb.rdat = 32'hAAAA_5555;
        #1;
        n_cmp++; if ({m0b.ack, m0b.err} !== 2'b00) begin n_fail++; $display("FAIL fl_ack_hidden: got %b expected 00", {m0b.ack, m0b.err}); end
        step();
        sb.ack = 0; sb.rdat = '0;
        m0b.cyc = 1; m0b.stb = 1; m0b.adr = 32'h8000_0040;
        #1;
        n_cmp++; if (sb.cyc !== 1'b0) begin n_fail++; $display("FAIL fl_idle: got %b expected 0", sb.cyc); end
        step();
        n_cmp++; if ({sb.cyc, sb.adr} !== {1'b1, 32'h8000_0040}) begin n_fail++; $display("FAIL fl_next_grant: got %h expected 180000040", {sb.cyc, sb.adr}); end
        sb.ack = 1; sb.rdat = 32'h0000_0013;
        #1;
        n_cmp++; if ({m0b.ack, m0b.rdat} !== {1'b1, 32'h0000_0013}) begin n_fail++; $display("FAIL fl_next_ack: got %h expected 100000013", {m0b.ack, m0b.rdat}); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        m1b.cyc = 1; m1b.stb = 1; m1b.adr = 32'h8000_0300;
        step();
        for (int c = 1; c <= 5; c++) begin
            n_cmp++; if ({sb.cyc, m1b.err, mem_wait_o} !== 3'b101) begin n_fail++; $display("FAIL to_wait_c%0d: got %b expected 101", c, {sb.cyc, m1b.err, mem_wait_o}); end
            step();
        end
        n_cmp++; if (m1b.err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", m1b.err); end
        n_cmp++; if ({sb.cyc, sb.stb, mem_wait_o, m1b.ack} !== 4'b0000) begin n_fail++; $display("FAIL to_abort: got %b expected 0000", {sb.cyc, sb.stb, mem_wait_o, m1b.ack}); end
        n_cmp++; if (m0b.err !== 1'b0) begin n_fail++; $display("FAIL to_m0_err: got %b expected 0", m0b.err); end
        m1b.cyc = 0; m1b.stb = 0;
        step();
        n_cmp++; if ({m1b.err, sb.cyc} !== 2'b00) begin n_fail++; $display("FAIL to_err_pulse: got %b expected 00", {m1b.err, sb.cyc}); end
    endtask

    task automatic test_ack_on_timeout();
        m1b.cyc = 1; m1b.stb = 1; m1b.adr = 32'h8000_0304;
        for (int c = 0; c < 5; c++) step();
        sb.ack = 1; sb.rdat = 32'h600D_600D;
        #1;
        n_cmp++; if ({sb.cyc, m1b.ack, m1b.err} !== 3'b110) begin n_fail++; $display("FAIL tack_ack: got %b expected 110", {sb.cyc, m1b.ack, m1b.err}); end
        step();
        sb.ack = 0; sb.rdat = '0; m1b.cyc = 0; m1b.stb = 0;
        #1;
        n_cmp++; if ({sb.cyc, m1b.err} !== 2'b00) begin n_fail++; $display("FAIL tack_no_err: got %b expected 00", {sb.cyc, m1b.err}); end
        step();
    endtask

    task automatic test_reset_mid();
        m1b.cyc = 1; m1b.stb = 1; m1b.we = 1; m1b.adr = 32'h8000_0400; m1b.sel = 4'b1000;
        step();
        sb.ack = 1;
        #1;
        n_cmp++; if ({sb.cyc, m1b.ack} !== 2'b11) begin n_fail++; $display("FAIL rm_own1: got %b expected 11", {sb.cyc, m1b.ack}); end
        #1;
        rst_n = 0;
        #1;
        n_cmp++; if ({sb.cyc, sb.stb, m1b.ack, m0b.ack, mem_wait_o} !== 5'b0) begin n_fail++; $display("FAIL rm_async: got %b expected 00000", {sb.cyc, sb.stb, m1b.ack, m0b.ack, mem_wait_o}); end
        sb.ack = 0;
        m0b.cyc = 1; m0b.stb = 1; m0b.adr = 32'h8000_0080;
        m1b.adr = 32'h8000_0500;
        @(negedge clk);
        rst_n = 1;
        #1;
        n_cmp++; if (sb.cyc !== 1'b0) begin n_fail++; $display("FAIL rm_idle: got %b expected 0", sb.cyc); end
        step();
        n_cmp++; if ({sb.cyc, sb.adr} !== {1'b1, 32'h8000_0500}) begin n_fail++; $display("FAIL rm_first_m1: got %h expected 180000500", {sb.cyc, sb.adr}); end
        sb.ack = 1;
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_m1_write();
        test_alternation();
        test_flush();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
